// File: rtl/mux_serializer_pkg.sv
// ============================================================================
// Module   : mux_serializer_pkg
// Brief    : Shared constants, state encodings and index helpers for mux_serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_serializer_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

    // First bit index of a word for the chosen bit order
    function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
        return msb_first ? SEL_HI : SEL_LO;
    endfunction

    // Index of the final bit of a word for the chosen bit order
    function automatic logic [SEL_W-1:0] sel_end(input logic msb_first);
        return msb_first ? SEL_LO : SEL_HI;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_serializer_mux8.sv
// ============================================================================
// Module   : mux8
// Brief    : 8:1 single-bit multiplexer cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux8
    import mux_serializer_pkg::*;
(
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    input  logic             i4,
    input  logic             i5,
    input  logic             i6,
    input  logic             i7,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    always_comb begin
        y = i0;
        case (s)
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            3'd7:    y = i7;
            default: y = i0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux_serializer.sv
// ============================================================================
// Module   : mux_serializer
// Brief    : Parallel-in/serial-out stage; byte in via valid/ready, bits out via valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter logic MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    input  logic              ser_ready
);

    localparam logic [SEL_W-1:0] c_SEL_START = sel_start(MSB_FIRST);
    localparam logic [SEL_W-1:0] c_SEL_END   = sel_end(MSB_FIRST);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;

    logic w_valid;
    logic w_last;
    logic w_mux_bit;
    logic w_load;
    logic w_accept;

    mux8 u_mux8 (
        .i0 (r_data[0]),
        .i1 (r_data[1]),
        .i2 (r_data[2]),
        .i3 (r_data[3]),
        .i4 (r_data[4]),
        .i5 (r_data[5]),
        .i6 (r_data[6]),
        .i7 (r_data[7]),
        .s  (r_sel),
        .y  (w_mux_bit)
    );

    assign w_valid  = (r_state == ST_SHIFT);
    assign w_last   = w_valid && (r_sel == c_SEL_END);
    assign w_accept = w_valid && ser_ready;

    // Ready combinationally on the last-bit accept so words stream without a gap
    assign in_ready = !flush && ((r_state == ST_IDLE) || (w_last && ser_ready));
    assign w_load   = in_valid && in_ready;

    assign ser_valid = w_valid;
    assign ser_last  = w_last;
    assign ser_out   = w_valid ? w_mux_bit : IDLE_LEVEL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_sel   <= c_SEL_START;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_sel   <= c_SEL_START;
        end else if (w_load) begin
            r_state <= ST_SHIFT;
            r_data  <= in_data;
            r_sel   <= c_SEL_START;
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= ST_IDLE;
                r_sel   <= c_SEL_START;
            end else begin
                r_sel <= MSB_FIRST ? (r_sel - 1'b1) : (r_sel + 1'b1);
            end
        end
    end

endmodule

`default_nettype wire
